conv1d_sram_reader: RTL and testbench

Initiator-side streaming reader for the conv1d accelerator's single-port SRAM macros: on a start command it issues `len` sequential read requests on the SRAM req/we/addr/wdata/be port (fixed 1-cycle read latency), buffers returned words in a 3-entry FIFO, and presents them as a valid/ready stream with a last marker. It sits between each conv1d SRAM instance and the datapath's input and weight loaders.

---
 rtl/conv1d_sram_reader_if.sv | 44 ++++
 rtl/conv1d_sram_reader.sv | 190 +++++++++++++++++++
 tb/tb_conv1d_sram_reader.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv1d_sram_reader_if.sv
// conv1d_sram_reader_if: SRAM request/response port plus the outgoing word
// stream of the conv1d SRAM reader.
//
// Handshake rules, in one place:
//   SRAM side  - req_o=1 issues a read of addr_o in that cycle; rdata_i holds
//                the word in the following cycle (fixed 1-cycle latency, no
//                stall). we_o/wdata_o/be_o are tied off (read-only use).
//   Stream     - a word transfers in every cycle where valid_o && ready_i.
//                Once valid_o is high, data_o/last_o hold until that
//                transfer. last_o is meaningful only while valid_o=1.
interface conv1d_sram_reader_if #(
  parameter int NUM_WORDS  = 128,
  parameter int DATA_WIDTH = 32
);
  localparam int AddrWidth = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  logic                    req_o;
  logic                    we_o;
  logic [AddrWidth-1:0]    addr_o;
  logic [DATA_WIDTH-1:0]   wdata_o;
  logic [DATA_WIDTH/8-1:0] be_o;
  logic [DATA_WIDTH-1:0]   rdata_i;

  logic [DATA_WIDTH-1:0]   data_o;
  logic                    valid_o;
  logic                    ready_i;
  logic                    last_o;

  // Reader side: drives the SRAM request and the stream.
  modport master (
    output req_o, we_o, addr_o, wdata_o, be_o,
    input  rdata_i,
    output data_o, valid_o, last_o,
    input  ready_i
  );

  // SRAM macro plus stream consumer side.
  modport slave (
    input  req_o, we_o, addr_o, wdata_o, be_o,
    output rdata_i,
    input  data_o, valid_o, last_o,
    output ready_i
  );
endinterface

// File: rtl/conv1d_sram_reader.sv
// conv1d_sram_reader: on start, reads len sequential words from a 1-cycle
// latency single-port SRAM, buffers them in a 3-entry FIFO and streams them
// out with a last marker. Issue is credit-limited so the FIFO never overflows.
// Optional feature macro: CONV1D_SRAM_READER_STRIDE_EN adds a captured
// address stride (stride_i); without it the stride is fixed at 1.
// dbg_state_o exposes the FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3).
module conv1d_sram_reader #(
  parameter  int NUM_WORDS  = 128,
  parameter  int DATA_WIDTH = 32,
  localparam int AddrWidth  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [AddrWidth:0]   len_i,
`ifdef CONV1D_SRAM_READER_STRIDE_EN
  input  logic [AddrWidth-1:0] stride_i,
`endif
  output logic                 busy_o,
  output logic                 done_o,
  output logic [1:0]           dbg_state_o,
  conv1d_sram_reader_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AddrWidth:0] NumWordsW = (AddrWidth+1)'(NUM_WORDS);
  localparam logic [AddrWidth:0] CntOne    = (AddrWidth+1)'(1);

  logic [1:0]            state_q, state_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [AddrWidth:0]    issue_left_q, issue_left_d;
  logic [AddrWidth:0]    deliver_left_q, deliver_left_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] fifo_mem_q [3];
  logic [DATA_WIDTH-1:0] fifo_mem_d [3];
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;

  logic [AddrWidth-1:0]  stride_val;
  logic [AddrWidth:0]    addr_sum;
  logic [AddrWidth-1:0]  addr_next;
  logic [2:0]            credit_used;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  valid;

`ifdef CONV1D_SRAM_READER_STRIDE_EN
  logic [AddrWidth-1:0]  stride_q, stride_d;
  assign stride_val = stride_q;
`else
  assign stride_val = AddrWidth'(1);
`endif

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit check uses registered occupancy only, so req_o never sees ready_i.
  always_comb begin
    credit_used = {1'b0, count_q} + {2'b00, inflight_q};
    issue       = (state_q == S_RUN) && (issue_left_q != '0) && (credit_used < 3'd3);
    push        = inflight_q;
    valid       = (count_q != 2'd0);
    pop         = valid && bus.ready_i;
  end

  // Next address: add stride and fold back into 0..NUM_WORDS-1 (two folds
  // cover any stride below 2**AddrWidth).
  always_comb begin
    addr_sum = {1'b0, addr_q} + {1'b0, stride_val};
    if (addr_sum >= NumWordsW) addr_sum = addr_sum - NumWordsW;
    if (addr_sum >= NumWordsW) addr_sum = addr_sum - NumWordsW;
    addr_next = addr_sum[AddrWidth-1:0];
  end

  // FSM, address register and the two word counters.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    issue_left_d   = issue_left_q;
    deliver_left_d = deliver_left_q;
    inflight_d     = issue;
`ifdef CONV1D_SRAM_READER_STRIDE_EN
    stride_d       = stride_q;
`endif
    if (issue) begin
      addr_d       = addr_next;
      issue_left_d = issue_left_q - CntOne;
    end
    if (pop) begin
      deliver_left_d = deliver_left_q - CntOne;
    end
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d         = base_addr_i;
          issue_left_d   = len_i;
          deliver_left_d = len_i;
`ifdef CONV1D_SRAM_READER_STRIDE_EN
          stride_d       = stride_i;
`endif
          state_d        = (len_i == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (issue && (issue_left_q == CntOne)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && (deliver_left_q == CntOne)) state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Response FIFO: captures rdata_i in the cycle after each request.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = bus.rdata_i;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards any in-flight response and buffered words.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      issue_left_q   <= '0;
      deliver_left_q <= '0;
      inflight_q     <= 1'b0;
      fifo_mem_q     <= '{default: '0};
      wr_ptr_q       <= 2'd0;
      rd_ptr_q       <= 2'd0;
      count_q        <= 2'd0;
`ifdef CONV1D_SRAM_READER_STRIDE_EN
      stride_q       <= '0;
`endif
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      issue_left_q   <= issue_left_d;
      deliver_left_q <= deliver_left_d;
      inflight_q     <= inflight_d;
      fifo_mem_q     <= fifo_mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
`ifdef CONV1D_SRAM_READER_STRIDE_EN
      stride_q       <= stride_d;
`endif
    end
  end

  // Output mapping; data_o reads zero whenever nothing is buffered.
  always_comb begin
    bus.req_o    = issue;
    bus.we_o     = 1'b0;
    bus.addr_o   = addr_q;
    bus.wdata_o  = '0;
    bus.be_o     = '1;
    bus.valid_o  = valid;
    bus.data_o   = valid ? fifo_mem_q[rd_ptr_q] : '0;
    bus.last_o   = valid && (deliver_left_q == CntOne);
    busy_o       = (state_q == S_RUN) || (state_q == S_DRAIN);
    done_o       = (state_q == S_DONE);
    dbg_state_o  = state_q;
  end

endmodule

// File: tb/tb_conv1d_sram_reader.sv
// tb_conv1d_sram_reader: scoreboard bench for conv1d_sram_reader. Expected
// addresses and stream words are computed from base/len/stride with plain
// modular arithmetic over a behavioural SRAM array.
module tb_conv1d_sram_reader;
  localparam int NUM_WORDS  = 128;
  localparam int DATA_WIDTH = 32;
  localparam int AW         = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          start;
  logic [AW-1:0] base;
  logic [AW:0]   len;
`ifdef CONV1D_SRAM_READER_STRIDE_EN
  logic [AW-1:0] stride;
`endif
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  conv1d_sram_reader_if #(.NUM_WORDS(NUM_WORDS), .DATA_WIDTH(DATA_WIDTH)) bus ();

  conv1d_sram_reader #(.NUM_WORDS(NUM_WORDS), .DATA_WIDTH(DATA_WIDTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .base_addr_i (base),
    .len_i       (len),
`ifdef CONV1D_SRAM_READER_STRIDE_EN
    .stride_i    (stride),
`endif
    .busy_o      (busy),
    .done_o      (done),
    .dbg_state_o (dbg_state),
    .bus         (bus)
  );

  // Behavioural SRAM: 1-cycle read latency, garbage when not addressed.
  logic [31:0] mem [NUM_WORDS];
  always @(posedge clk) bus.rdata_i <= bus.req_o ? mem[bus.addr_o] : $urandom;

  // Ready generator: 0 = always high, 1 = random, 2 = 1,0,0 repeating.
  int ready_mode = 0;
  initial begin
    bus.ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.ready_i = 1'b1;
        1:       bus.ready_i = 1'($urandom_range(0, 1));
        default: bus.ready_i = ((cyc % 3) == 0);
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [32:0]   exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int issued = 0;
  int popped = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations on every stream handshake and SRAM request.
  always @(negedge clk) begin
    if (rst) begin
      issued = 0;
      popped = 0;
      exp_q.delete();
      exp_addr_q.delete();
    end else begin
      logic [32:0] e;
      int outstanding;
      outstanding = issued - popped;
      check("credit_limit", 32'(outstanding > 3 || (outstanding == 3 && bus.req_o)), 32'd0);
      if (bus.valid_o && bus.ready_i) begin
        check("sb_has_word", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("stream_data", bus.data_o, e[31:0]);
          check("stream_last", 32'(bus.last_o), 32'(e[32]));
        end
        popped++;
      end
      if (bus.req_o) begin
        check("sb_has_addr", 32'(exp_addr_q.size() != 0), 32'd1);
        if (exp_addr_q.size() != 0) check("req_addr", 32'(bus.addr_o), 32'(exp_addr_q.pop_front()));
        check("req_tieoffs", {bus.we_o, bus.be_o, 27'(bus.wdata_o != 0)}, {1'b0, 4'hF, 27'd0});
        issued++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(bus.req_o),   32'd0);
    check({tag, "_valid"}, 32'(bus.valid_o), 32'd0);
    check({tag, "_last"},  32'(bus.last_o),  32'd0);
    check({tag, "_busy"},  32'(busy),        32'd0);
    check({tag, "_done"},  32'(done),        32'd0);
    check({tag, "_addr"},  32'(bus.addr_o),  32'd0);
    check({tag, "_data"},  bus.data_o,       32'd0);
    check({tag, "_state"}, 32'(dbg_state),   32'd0);
  endtask

  task automatic push_expected(input int b, input int l, input int st);
    for (int i = 0; i < l; i++) begin
      int a;
      a = (b + i * st) % NUM_WORDS;
      exp_addr_q.push_back(AW'(a));
      exp_q.push_back({(i == l - 1), mem[a]});
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; rst = 1'b1; start = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  // One transfer: start in cycle 0, observe until done_o or budget expiry.
  task automatic run_xfer(input int b, input int l, input int s, input bit timed, input bit mid_start);
    int st, done_cyc, busy_cnt, req_cnt, first_valid, budget;
    bit got;
`ifdef CONV1D_SRAM_READER_STRIDE_EN
    st = s;
`else
    st = 1;
    if (s != 1) $display("note: stride %0d has no effect in this build", s);
`endif
    budget = 40 * l + 20;
    busy_cnt = 0; req_cnt = 0; first_valid = -1; done_cyc = -1; got = 1'b0;
    push_expected(b, l, st);
    @(posedge clk); #1;
    start = 1'b1; base = AW'(b); len = (AW+1)'(l);
`ifdef CONV1D_SRAM_READER_STRIDE_EN
    stride = AW'(s);
`endif
    @(posedge clk); #1;
    start = 1'b0; base = AW'($urandom); len = (AW+1)'($urandom);
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (bus.req_o) req_cnt++;
      if (bus.valid_o && first_valid < 0) first_valid = k;
      if (done) begin
        done_cyc = k;
        got = 1'b1;
        break;
      end
      if (mid_start) start = (k == 2);
    end
    start = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    if (!got) begin
      pulse_reset();
    end else begin
      check("req_count", 32'(req_cnt), 32'(l));
      if (timed) begin
        check("done_cycle",  32'(done_cyc),    32'((l == 0) ? 1 : l + 3));
        check("busy_cycles", 32'(busy_cnt),    32'((l == 0) ? 0 : l + 2));
        check("first_valid", 32'(first_valid), 32'((l == 0) ? -1 : 3));
      end
      @(negedge clk);
      check("done_pulse_1cyc", 32'(done), 32'd0);
      check("idle_not_busy",   32'(busy), 32'd0);
      check("sb_words_left",   32'(exp_q.size()), 32'd0);
      check("sb_addrs_left",   32'(exp_addr_q.size()), 32'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    start = 1'b0; base = '0; len = '0;
`ifdef CONV1D_SRAM_READER_STRIDE_EN
    stride = AW'(1);
`endif
    for (int i = 0; i < NUM_WORDS; i++) mem[i] = 32'(i);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    #1 rst = 1'b0;

    // Directed: basic, zero length, wrap-around.
    run_xfer(5, 4, 1, 1'b1, 1'b0);
    run_xfer(9, 0, 1, 1'b1, 1'b0);
    run_xfer(126, 4, 1, 1'b1, 1'b0);

    // Backpressure pattern 1,0,0,...
    ready_mode = 2;
    run_xfer(20, 8, 1, 1'b0, 1'b0);
    ready_mode = 0;

    // Reset asserted in cycle 4 of a 16-word transfer.
    push_expected(40, 16, 1);
    @(posedge clk); #1;
    start = 1'b1; base = AW'(40); len = (AW+1)'(16);
`ifdef CONV1D_SRAM_READER_STRIDE_EN
    stride = AW'(1);
`endif
    @(posedge clk); #1; start = 1'b0;
    for (int k = 1; k <= 4; k++) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(bus.valid_o), 32'd0);
      check("post_rst_req",   32'(bus.req_o),   32'd0);
    end
    run_xfer(5, 4, 1, 1'b1, 1'b0);

    // start pulsed mid-transfer must be ignored.
    run_xfer(60, 6, 1, 1'b1, 1'b1);

`ifdef CONV1D_SRAM_READER_STRIDE_EN
    run_xfer(10, 3, 3, 1'b1, 1'b0);
    run_xfer(30, 4, 0, 1'b1, 1'b0);
    run_xfer(120, 5, 7, 1'b1, 1'b1);
`endif

    // Randomized transfers over random SRAM contents with random ready.
    for (int i = 0; i < NUM_WORDS; i++) mem[i] = $urandom;
    ready_mode = 1;
    for (int n = 0; n < 14; n++) begin
      int s;
`ifdef CONV1D_SRAM_READER_STRIDE_EN
      s = $urandom_range(0, 127);
`else
      s = 1;
`endif
      run_xfer($urandom_range(0, 127), $urandom_range(0, 20), s, 1'b0, 1'b0);
    end
    ready_mode = 0;

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
